// File: rtl/led_mmio_pkg.sv
// Shared definitions for the memory-mapped LED peripheral: register offsets,
// CTRL bit positions and the rotate helper.
package led_mmio_pkg;

  localparam logic [1:0] LED_DATA_OFS = 2'd0;
  localparam logic [1:0] CTRL_OFS     = 2'd1;
  localparam logic [1:0] PERIOD_OFS   = 2'd2;
  localparam logic [1:0] STATUS_OFS   = 2'd3;

  localparam int CTRL_ROT_EN = 0;
  localparam int CTRL_DIR    = 1;

  typedef enum logic {
    ROT_LEFT  = 1'b0,
    ROT_RIGHT = 1'b1
  } rot_dir_t;

  function automatic logic [7:0] rotate8(logic [7:0] v, rot_dir_t dir);
    return (dir == ROT_RIGHT) ? {v[0], v[7:1]} : {v[6:0], v[7]};
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Rotation prescaler: pulses tick once every max(period,1) enabled cycles.
module led_prescaler #(
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count_q, count_d;
  logic [DIV_WIDTH-1:0] count_max;

  always_comb begin
    // a programmed period of 0 behaves like 1 (tick every cycle)
    count_max = (period == '0) ? '0 : period - DIV_WIDTH'(1);
    tick      = en && (count_q == count_max);
    count_d   = count_q + DIV_WIDTH'(1);
    if (!en || clr || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_mmio.sv
// LED peripheral on the core's data port: four-word register window with
// optional hardware rotation of the LED pattern and a rotation counter.
module led_mmio
  import led_mmio_pkg::*;
#(
  parameter logic [31:0]          BASE_ADDR      = 32'hFFFF_FF00,
  parameter int                   DIV_WIDTH      = 24,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_PERIOD = DIV_WIDTH'(50)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        hit,
  output logic [7:0]  led
);

  logic [7:0]           led_data_q, led_data_d;
  logic [1:0]           ctrl_q, ctrl_d;
  logic [DIV_WIDTH-1:0] period_q, period_d;
  logic [15:0]          rotcnt_q, rotcnt_d;

  logic       wr_en;
  logic [1:0] ofs;
  logic       wr_led, wr_ctrl, wr_period;
  logic       tick;
  logic [31:0] period_rd;
  logic       unused_bits;

  assign hit         = (DataAdr[31:4] == BASE_ADDR[31:4]);
  assign ofs         = DataAdr[3:2];
  assign wr_en       = MemWrite && hit;
  assign wr_led      = wr_en && (ofs == LED_DATA_OFS);
  assign wr_ctrl     = wr_en && (ofs == CTRL_OFS);
  assign wr_period   = wr_en && (ofs == PERIOD_OFS);
  assign unused_bits = ^{DataAdr[1:0], WriteData};

  led_prescaler #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en     (ctrl_q[CTRL_ROT_EN]),
    .clr    (wr_ctrl || wr_period),
    .period (period_q),
    .tick   (tick)
  );

  always_comb begin
    led_data_d = led_data_q;
    ctrl_d     = ctrl_q;
    period_d   = period_q;
    rotcnt_d   = rotcnt_q;

    // a store to LED_DATA in a tick cycle wins and the tick is dropped
    if (wr_led) begin
      led_data_d = WriteData[7:0];
    end else if (tick) begin
      led_data_d = rotate8(led_data_q, rot_dir_t'(ctrl_q[CTRL_DIR]));
      rotcnt_d   = rotcnt_q + 16'd1;
    end

    if (wr_ctrl) begin
      ctrl_d = WriteData[1:0];
    end
    if (wr_period) begin
      period_d = WriteData[DIV_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_data_q <= '0;
      ctrl_q     <= '0;
      period_q   <= DEFAULT_PERIOD;
      rotcnt_q   <= '0;
    end else begin
      led_data_q <= led_data_d;
      ctrl_q     <= ctrl_d;
      period_q   <= period_d;
      rotcnt_q   <= rotcnt_d;
    end
  end

  always_comb begin
    period_rd                  = '0;
    period_rd[DIV_WIDTH-1:0]   = period_q;
    ReadData                   = '0;
    if (hit) begin
      unique case (ofs)
        LED_DATA_OFS: ReadData = {24'h0, led_data_q};
        CTRL_OFS:     ReadData = {30'h0, ctrl_q};
        PERIOD_OFS:   ReadData = period_rd;
        STATUS_OFS:   ReadData = {16'h0, rotcnt_q};
        default:      ReadData = '0;
      endcase
    end
  end

  assign led = led_data_q;

endmodule

// File: tb/tb_led_mmio.sv
// Directed bench for led_mmio; expectations queue up as stimulus is applied
// and are compared as the DUT outputs are sampled.
module tb_led_mmio;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam logic [31:0] A_LED    = BASE + 32'h0;
  localparam logic [31:0] A_CTRL   = BASE + 32'h4;
  localparam logic [31:0] A_PERIOD = BASE + 32'h8;
  localparam logic [31:0] A_STATUS = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        hit;
  logic [7:0]  led;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  led_mmio dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .hit       (hit),
    .led       (led)
  );

  always #5 clk = ~clk;

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wr(logic [31:0] adr, logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = adr;
    WriteData = d;
    step();
    MemWrite  = 1'b0;
    DataAdr   = 32'h0;
    WriteData = 32'h0;
  endtask

  task automatic push_exp(string tag, logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic compare(logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $error("FAIL sb_empty: observed 0x%08h required an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.val);
    end
  endtask

  task automatic rd(logic [31:0] adr, logic [31:0] v, string tag);
    push_exp(tag, v);
    DataAdr = adr;
    #1;
    compare(ReadData);
  endtask

  task automatic chk_led(logic [7:0] v, string tag);
    push_exp(tag, {24'h0, v});
    compare({24'h0, led});
  endtask

  task automatic chk_hit(logic [31:0] adr, logic v, string tag);
    push_exp(tag, {31'h0, v});
    DataAdr = adr;
    #1;
    compare({31'h0, hit});
  endtask

  initial begin
    reset     = 1'b1;
    MemWrite  = 1'b0;
    DataAdr   = 32'h0;
    WriteData = 32'h0;
    step(2);
    reset = 1'b0;

    // reset state
    chk_led(8'h00, "rst_led");
    rd(A_LED,    32'h0,  "rst_led_data");
    rd(A_CTRL,   32'h0,  "rst_ctrl");
    rd(A_PERIOD, 32'd50, "rst_period");
    rd(A_STATUS, 32'h0,  "rst_status");
    chk_hit(A_LED, 1'b1, "hit_in_window");

    // plain store, out-of-window store, read-only STATUS, upper bits
    wr(A_LED, 32'h0000_00A5);
    chk_led(8'hA5, "store_a5");
    wr(BASE + 32'h10, 32'h0000_003C);
    chk_led(8'hA5, "oob_store_ignored");
    chk_hit(BASE + 32'h10, 1'b0, "oob_hit");
    rd(BASE + 32'h10, 32'h0, "oob_read_zero");
    wr(A_STATUS, 32'h0000_1234);
    rd(A_STATUS, 32'h0, "status_ro");
    wr(A_LED, 32'hFFFF_FF5A);
    rd(A_LED, 32'h0000_005A, "led_upper_zero");

    // rotate left, PERIOD=4
    wr(A_LED, 32'h01);
    wr(A_PERIOD, 32'd4);
    wr(A_CTRL, 32'h1);
    step(3);
    chk_led(8'h01, "rot_before_period");
    step(1);
    chk_led(8'h02, "rot_first_tick");
    step(4);
    chk_led(8'h04, "rot_second_tick");
    rd(A_STATUS, 32'd2, "rotcnt_2");

    // store exactly in the tick cycle: write wins, no count
    step(3);
    wr(A_LED, 32'h0F);
    chk_led(8'h0F, "collide_write_wins");
    rd(A_STATUS, 32'd2, "collide_rotcnt_held");
    step(3);
    chk_led(8'h0F, "collide_no_early_rot");
    step(1);
    chk_led(8'h1E, "collide_next_rot");
    rd(A_STATUS, 32'd3, "rotcnt_3");
    rd(A_CTRL, 32'h1, "ctrl_readback");
    wr(A_CTRL, 32'h0);

    // rotate right, PERIOD=1
    wr(A_LED, 32'h01);
    wr(A_PERIOD, 32'd1);
    wr(A_CTRL, 32'h3);
    step(1);
    chk_led(8'h80, "right_p1_first");
    step(1);
    chk_led(8'h40, "right_p1_second");
    rd(A_STATUS, 32'd5, "rotcnt_5");

    // reset mid-rotation with a same-cycle store
    reset     = 1'b1;
    MemWrite  = 1'b1;
    DataAdr   = A_LED;
    WriteData = 32'h77;
    step(1);
    reset     = 1'b0;
    MemWrite  = 1'b0;
    chk_led(8'h00, "midrst_led");
    rd(A_CTRL,   32'h0,  "midrst_ctrl");
    rd(A_PERIOD, 32'd50, "midrst_period");
    rd(A_STATUS, 32'h0,  "midrst_status");
    step(2);
    chk_led(8'h00, "midrst_stays_idle");

    // PERIOD=0 behaves like 1
    wr(A_LED, 32'h01);
    wr(A_PERIOD, 32'd0);
    rd(A_PERIOD, 32'd0, "period0_readback");
    wr(A_CTRL, 32'h3);
    step(1);
    chk_led(8'h80, "p0_first");
    step(1);
    chk_led(8'h40, "p0_second");
    step(1);
    chk_led(8'h20, "p0_third");

    // 0xFF rotates to itself but still counts
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    wr(A_LED, 32'hFF);
    wr(A_PERIOD, 32'd1);
    wr(A_CTRL, 32'h1);
    step(1);
    chk_led(8'hFF, "ff_self");
    rd(A_STATUS, 32'd1, "ff_rotcnt_1");
    step(1);
    rd(A_STATUS, 32'd2, "ff_rotcnt_2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
